// File: rtl/game_pkg.sv
// Shared types and constants for the Frogger game-state controller.
package game_pkg;

  localparam int TIME_W         = 6;
  localparam int DEFAULT_GOAL_Y = 90;

  typedef enum logic [2:0] {
    PLAY     = 3'd0,
    DEATH    = 3'd1,
    ADVANCE  = 3'd2,
    GAMEOVER = 3'd3,
    WIN      = 3'd4
  } game_state_t;

endpackage

// File: rtl/sec_tick.sv
// One-second enable generator: counts clk_in cycles to CLK_HZ-1 and emits a one-cycle tick_o.
module sec_tick #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic en,
  input  logic clr,
  output logic tick_o
);

  localparam int               CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign tick_o = en && !clr && (count_reg == LAST);

endmodule

// File: rtl/game_state_ctrl.sv
// Frogger game-state controller: level, lives, per-life countdown and play/death/advance/gameover/win.
// Define GAME_TIMER_EN to enable the per-life countdown and its timeout.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int NUM_LEVELS  = 5,
  parameter int START_LIVES = 4,
  parameter int LEVEL_W     = 3,
  parameter int LIVES_W     = 3,
  parameter int Y_W         = 9,
  parameter int GOAL_Y      = DEFAULT_GOAL_Y,
  parameter int CLK_HZ      = 100_000_000,
  parameter int ROUND_SECS  = 30,
  parameter int RESPAWN_CYC = 4
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               collision_i,
  input  logic [Y_W-1:0]     frog_y_i,
  input  logic               start_i,
  output logic               respawn_o,
  output logic               gameover_o,
  output logic               gamewin_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic [LIVES_W-1:0] lives_o,
  output logic [TIME_W-1:0]  time_left_o
);

  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
  localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(START_LIVES);
  localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);
  localparam logic [Y_W-1:0]     GOAL_ROW   = Y_W'(GOAL_Y);
  localparam int                 RC_W       = (RESPAWN_CYC > 1) ? $clog2(RESPAWN_CYC) : 1;
  localparam logic [RC_W-1:0]    RC_LAST    = RC_W'(RESPAWN_CYC - 1);

  game_state_t        state_reg, state_next;
  logic [LEVEL_W-1:0] level_reg, level_next;
  logic [LIVES_W-1:0] lives_reg, lives_next;
  logic [RC_W-1:0]    rc_reg, rc_next;
  logic               timeout;

  always_comb begin
    state_next = state_reg;
    level_next = level_reg;
    lives_next = lives_reg;
    rc_next    = rc_reg;
    case (state_reg)
      PLAY: begin
        rc_next = '0;
        // A hit outranks reaching the goal; a hit plus timeout still costs one life.
        if (collision_i || timeout) begin
          lives_next = (lives_reg > ONE_LIFE) ? lives_reg - ONE_LIFE : '0;
          state_next = (lives_reg > ONE_LIFE) ? DEATH : GAMEOVER;
        end else if (frog_y_i <= GOAL_ROW) begin
          if (level_reg < LAST_LEVEL) begin
            level_next = level_reg + 1'b1;
            lives_next = FULL_LIVES;
            state_next = ADVANCE;
          end else begin
            state_next = WIN;
          end
        end
      end
      DEATH, ADVANCE: begin
        if (rc_reg == RC_LAST) begin
          rc_next    = '0;
          state_next = PLAY;
        end else begin
          rc_next = rc_reg + 1'b1;
        end
      end
      GAMEOVER, WIN: begin
        if (start_i) begin
          state_next = PLAY;
          level_next = '0;
          lives_next = FULL_LIVES;
        end
      end
      default: begin
        state_next = PLAY;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_reg  <= PLAY;
      level_reg  <= '0;
      lives_reg  <= FULL_LIVES;
      rc_reg     <= '0;
      respawn_o  <= 1'b0;
      gameover_o <= 1'b0;
      gamewin_o  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      level_reg  <= level_next;
      lives_reg  <= lives_next;
      rc_reg     <= rc_next;
      respawn_o  <= (state_next == DEATH) || (state_next == ADVANCE);
      gameover_o <= (state_next == GAMEOVER);
      gamewin_o  <= (state_next == WIN);
    end
  end

  assign level_o = level_reg;
  assign lives_o = lives_reg;

`ifdef GAME_TIMER_EN
  localparam logic [TIME_W-1:0] ROUND_T = TIME_W'(ROUND_SECS);

  logic              in_play, tick, reload;
  logic [TIME_W-1:0] time_reg;

  assign in_play = (state_reg == PLAY);
  assign reload  = !in_play && (state_next == PLAY);

  sec_tick #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .en      (in_play),
    .clr     (!in_play),
    .tick_o  (tick)
  );

  // The countdown freezes on the very edge that leaves PLAY.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      time_reg <= ROUND_T;
    end else if (reload) begin
      time_reg <= ROUND_T;
    end else if (in_play && (state_next == PLAY) && tick && (time_reg != '0)) begin
      time_reg <= time_reg - 1'b1;
    end
  end

  assign timeout     = in_play && (time_reg == '0);
  assign time_left_o = time_reg;
`else
  logic unused_timer_cfg;
  assign unused_timer_cfg = ^{CLK_HZ, ROUND_SECS};
  assign timeout          = 1'b0;
  assign time_left_o      = '0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: a cycle model queues expected outputs per stimulus cycle.
module tb_game_state_ctrl;

  localparam int NL = 5, SL = 4, GOAL = 90, CLK_DIV = 10, RSECS = 3, RCYC = 4;
`ifdef GAME_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam int S_PLAY = 0, S_DEATH = 1, S_ADV = 2, S_OVER = 3, S_WIN = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       collision;
  logic [8:0] frog_y;
  logic       start;
  logic       respawn, gameover, gamewin;
  logic [2:0] level, lives;
  logic [5:0] time_left;

  always #5 clk = ~clk;

  game_state_ctrl #(
    .NUM_LEVELS (NL),
    .START_LIVES(SL),
    .LEVEL_W    (3),
    .LIVES_W    (3),
    .Y_W        (9),
    .GOAL_Y     (GOAL),
    .CLK_HZ     (CLK_DIV),
    .ROUND_SECS (RSECS),
    .RESPAWN_CYC(RCYC)
  ) dut (
    .clk_in     (clk),
    .reset_in   (reset_n),
    .collision_i(collision),
    .frog_y_i   (frog_y),
    .start_i    (start),
    .respawn_o  (respawn),
    .gameover_o (gameover),
    .gamewin_o  (gamewin),
    .level_o    (level),
    .lives_o    (lives),
    .time_left_o(time_left)
  );

  typedef struct {
    int respawn;
    int gameover;
    int gamewin;
    int level;
    int lives;
    int tleft;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;
  int   m_st, m_level, m_lives, m_time, m_rc, m_pre;

  task automatic check_eq(input string tag, input int obs, input int want);
    total++;
    if (obs != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_st    = S_PLAY;
    m_level = 0;
    m_lives = SL;
    m_time  = TIMER ? RSECS : 0;
    m_rc    = 0;
    m_pre   = 0;
  endtask

  task automatic model_step(input int c, input int y, input int s);
    int tick, tout, nxt_pre;
    tick    = (TIMER && m_st == S_PLAY && m_pre == CLK_DIV - 1) ? 1 : 0;
    tout    = (TIMER && m_st == S_PLAY && m_time == 0) ? 1 : 0;
    nxt_pre = (m_st == S_PLAY) ? (m_pre + 1) % CLK_DIV : 0;
    case (m_st)
      S_PLAY: begin
        if (c != 0 || tout != 0) begin
          m_lives = m_lives - 1;
          m_st    = (m_lives == 0) ? S_OVER : S_DEATH;
          m_rc    = 0;
        end else if (y <= GOAL) begin
          if (m_level < NL - 1) begin
            m_level = m_level + 1;
            m_lives = SL;
            m_st    = S_ADV;
            m_rc    = 0;
          end else begin
            m_st = S_WIN;
          end
        end else if (tick != 0 && m_time > 0) begin
          m_time = m_time - 1;
        end
      end
      S_DEATH, S_ADV: begin
        m_rc = m_rc + 1;
        if (m_rc == RCYC) begin
          m_st   = S_PLAY;
          m_time = TIMER ? RSECS : 0;
        end
      end
      default: begin
        if (s != 0) begin
          m_st    = S_PLAY;
          m_level = 0;
          m_lives = SL;
          m_time  = TIMER ? RSECS : 0;
        end
      end
    endcase
    m_pre = nxt_pre;
  endtask

  task automatic step(input logic c, input int y, input logic s);
    exp_t e;
    collision = c;
    frog_y    = 9'(y);
    start     = s;
    model_step(int'(c), y, int'(s));
    e.respawn  = (m_st == S_DEATH || m_st == S_ADV) ? 1 : 0;
    e.gameover = (m_st == S_OVER) ? 1 : 0;
    e.gamewin  = (m_st == S_WIN) ? 1 : 0;
    e.level    = m_level;
    e.lives    = m_lives;
    e.tleft    = m_time;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("respawn", int'(respawn), e.respawn);
    check_eq("gameover", int'(gameover), e.gameover);
    check_eq("gamewin", int'(gamewin), e.gamewin);
    check_eq("level", int'(level), e.level);
    check_eq("lives", int'(lives), e.lives);
    check_eq("time_left", int'(time_left), e.tleft);
    txn++;
    $display("txn %0d c=%0d y=%0d s=%0d resp=%0d go=%0d win=%0d lvl=%0d lives=%0d t=%0d",
             txn, c, y, s, respawn, gameover, gamewin, level, lives, time_left);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 300, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, l0;
    collision = 1'b0;
    frog_y    = 9'd300;
    start     = 1'b0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_lives", int'(lives), SL);
    check_eq("rst_level", int'(level), 0);
    check_eq("rst_respawn", int'(respawn), 0);
    check_eq("rst_gameover", int'(gameover), 0);
    check_eq("rst_gamewin", int'(gamewin), 0);
    check_eq("rst_time", int'(time_left), TIMER ? RSECS : 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    idle(5);

    // Single collision, with inputs toggling during the respawn hold
    step(1'b1, 300, 1'b0);
    check_eq("coll_lives", int'(lives), 3);
    check_eq("coll_respawn", int'(respawn), 1);
    n = 0;
    while (respawn && n < 20) begin
      n++;
      step(1'b1, 50, 1'b0);
    end
    check_eq("respawn_len", n, RCYC);
    check_eq("death_ignore_lives", int'(lives), 3);
    check_eq("death_ignore_level", int'(level), 0);
    check_eq("respawn_time", int'(time_left), TIMER ? RSECS : 0);
    step(1'b0, 300, 1'b1);
    check_eq("start_in_play", int'(lives), 3);

    // Drain the remaining lives
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 300, 1'b0);
      idle(4);
    end
    check_eq("go_flag", int'(gameover), 1);
    check_eq("go_lives", int'(lives), 0);
    for (int k = 0; k < 3; k++) step(1'b1, 300, 1'b0);
    step(1'b0, 50, 1'b0);
    check_eq("go_frozen_lives", int'(lives), 0);
    check_eq("go_frozen_level", int'(level), 0);
    step(1'b0, 300, 1'b1);
    check_eq("restart_lives", int'(lives), SL);
    check_eq("restart_level", int'(level), 0);
    check_eq("restart_go", int'(gameover), 0);

    // Level advance refills lives
    step(1'b1, 300, 1'b0);
    idle(4);
    step(1'b1, 300, 1'b0);
    idle(4);
    check_eq("two_lives", int'(lives), 2);
    step(1'b0, 90, 1'b0);
    check_eq("adv_level", int'(level), 1);
    check_eq("adv_lives", int'(lives), SL);
    check_eq("adv_respawn", int'(respawn), 1);
    idle(4);
    for (int k = 2; k < NL; k++) begin
      step(1'b0, 90, 1'b0);
      idle(4);
    end
    check_eq("top_level", int'(level), NL - 1);
    step(1'b0, 50, 1'b0);
    check_eq("win_flag", int'(gamewin), 1);
    check_eq("win_level", int'(level), NL - 1);
    step(1'b0, 90, 1'b0);
    step(1'b1, 300, 1'b0);
    check_eq("win_level_cap", int'(level), NL - 1);
    check_eq("win_lives_frozen", int'(lives), SL);
    step(1'b0, 300, 1'b1);
    check_eq("win_restart_level", int'(level), 0);
    check_eq("win_restart_flag", int'(gamewin), 0);

    // Collision and goal together: collision wins
    step(1'b1, 80, 1'b0);
    check_eq("coll_goal_lives", int'(lives), SL - 1);
    check_eq("coll_goal_level", int'(level), 0);
    idle(4);

    // Asynchronous reset in the middle of a respawn hold
    step(1'b1, 300, 1'b0);
    step(1'b0, 300, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_respawn", int'(respawn), 0);
    check_eq("midrst_lives", int'(lives), SL);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

`ifdef GAME_TIMER_EN
    l0 = int'(lives);
    n  = 0;
    while (int'(lives) == l0 && n < 100) begin
      n++;
      step(1'b0, 300, 1'b0);
    end
    check_eq("timeout_cycles", n, CLK_DIV * RSECS + 1);
    idle(4);
    n = 0;
    while (time_left != 6'd0 && n < 100) begin
      n++;
      step(1'b0, 300, 1'b0);
    end
    check_eq("time_zero", int'(time_left), 0);
    l0 = int'(lives);
    step(1'b1, 300, 1'b0);
    check_eq("timeout_coll_single", int'(lives), l0 - 1);
    idle(4);
`else
    l0 = int'(lives);
    idle(40);
    check_eq("no_timeout", int'(lives), l0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
